alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter FLAGS_RESET, default 32'h0000_0002, meaning the value eflags takes on reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1 each, meaning the requester presents an ALU operation.
REQ-005 SHALL have ports req0_ready/req1_ready, output, 1 each, meaning the request is accepted this cycle.
REQ-006 SHALL have ports req0_op/req1_op (input, 3) and req0_a/req0_b/req1_a/req1_b (input, 32): op code and operands.
REQ-007 SHALL have ports alu_op (output, 3), alu_a/alu_b (output, 32), alu_cf_fwd/alu_af_fwd (output, 1) driving the shared alu32.
REQ-008 SHALL have ports alu_out (input, 32) and alu_flags (input, 32), the combinational alu32 result and flags.
REQ-009 SHALL have ports rsp_valid (output, 1), rsp_id (output, 1), rsp_result (output, 32), rsp_flags (output, 32), rsp_ready (input, 1): registered response.
REQ-010 SHALL have port eflags, output, 32, the architectural flag register.

Function
REQ-011 Op encoding SHALL be 0 ADD, 1 OR, 2 NOT, 3 DAA, 4 AND, 5 CLD, 6 CMP, 7 STD.
REQ-012 Slot free = !rsp_valid | rsp_ready; at most one request is granted per cycle, and only when the slot is free.
REQ-013 reqN_ready SHALL be high only for the granted requester, combinationally in the same cycle; a transfer occurs on valid & ready.
REQ-014 alu_op/alu_a/alu_b SHALL mux the granted requester's fields, or requester 0's fields when none is granted.
REQ-015 alu_cf_fwd = eflags[0] and alu_af_fwd = eflags[4], taken from the register, never from the in-flight result.
REQ-016 On transfer, the next edge SHALL load rsp_result = alu_out, rsp_flags = alu_flags, rsp_id = granted index, and set rsp_valid=1; latency is 1 cycle.
REQ-017 When rsp_valid & !rsp_ready, all rsp_* SHALL hold stable, and no grant is issued.
REQ-018 When rsp_valid & rsp_ready with no new transfer, rsp_valid SHALL clear at the next edge.
REQ-019 When rsp_valid & rsp_ready coincide with a new transfer, rsp_valid SHALL stay 1 and the new data SHALL load, giving full throughput.
REQ-020 On transfer, ADD/OR/AND/CMP/DAA SHALL write eflags bits 0,2,4,6,7,11 (CF,PF,AF,ZF,SF,OF) from alu_flags; NOT SHALL write no flags; CLD/STD SHALL write only bit 10 (DF).
REQ-021 Unwritten eflags bits SHALL hold, and bit 1 SHALL always read 1.
REQ-022 eflags SHALL update on the transfer edge, so a back-to-back DAA observes the prior op's CF/AF.
REQ-023 A request whose valid drops before transfer is not serviced; the arbiter keeps no memory of it.

Reset
REQ-024 When reset=1 at an edge: rsp_valid=0, rsp_id=0, rsp_result=0, rsp_flags=0, eflags=FLAGS_RESET, round-robin pointer=0 (requester 0 preferred).
REQ-025 Reset SHALL override any same-cycle transfer; a pending response is discarded and eflags is not updated.
REQ-026 reqN_ready SHALL be 0 whenever reset=1.

Configuration
REQ-027 With macro ALU_ARB_ROUND_ROBIN_EN defined: on contention, grant goes to the requester not granted last; the pointer updates only on a transfer.
REQ-028 Without ALU_ARB_ROUND_ROBIN_EN: fixed priority, requester 0 always wins, and no pointer register exists.

Verification
REQ-029 After reset, req0 ADD a=32'hFFFF_FFFF b=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=0, eflags=32'h0000_0057.
REQ-030 Then req1 DAA a=32'h0000_000F (with CF=0 and AF=0 in eflags) -> rsp_result=32'h15, eflags CF=0, AF=1, PF=0, ZF=0.
REQ-031 Both valid every cycle, rsp_ready=1, macro defined -> grants alternate 0,1,0,1 starting with 0, one response per cycle; macro undefined -> all grants to 0.
REQ-032 rsp_ready=0 for 3 cycles with a response pending -> both readies 0 and rsp_* stable; rsp_ready=1 -> pending response consumed and a new grant issued the same cycle.
REQ-033 STD, then NOT a=0 -> eflags bit10=1 after STD, eflags unchanged by NOT, rsp_result=32'hFFFF_FFFF; reset asserted with a transfer -> rsp_valid=0 and eflags=32'h2.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared alu32 with a registered response slot and eflags register.
// Define ALU_ARB_ROUND_ROBIN_EN for round-robin contention handling; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter logic [31:0] FLAGS_RESET = 32'h0000_0002
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [2:0]  req0_op,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [2:0]  req1_op,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    output logic [2:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_cf_fwd,
    output logic        alu_af_fwd,
    input  logic [31:0] alu_out,
    input  logic [31:0] alu_flags,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic [31:0] rsp_result,
    output logic [31:0] rsp_flags,
    input  logic        rsp_ready,
    output logic [31:0] eflags
);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_OR  = 3'd1,
        OP_NOT = 3'd2,
        OP_DAA = 3'd3,
        OP_AND = 3'd4,
        OP_CLD = 3'd5,
        OP_CMP = 3'd6,
        OP_STD = 3'd7
    } op_e;

    // CF, PF, AF, ZF, SF, OF for arithmetic/logic ops; DF alone for CLD/STD
    localparam logic [31:0] ARITH_MASK = 32'h0000_08D5;
    localparam logic [31:0] DF_MASK    = 32'h0000_0400;
    localparam logic [31:0] FIXED_ONE  = 32'h0000_0002;

    logic        rspValid_q, rspValid_d;
    logic        rspId_q, rspId_d;
    logic [31:0] rspResult_q, rspResult_d;
    logic [31:0] rspFlags_q, rspFlags_d;
    logic [31:0] eflags_q, eflags_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
    logic        rrPtr_q, rrPtr_d;
`endif

    logic        slotFree;
    logic        grant0, grant1, transfer;
    logic [31:0] flagMask;
    op_e         grantOp;

    assign slotFree = !rspValid_q || rsp_ready;

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset && slotFree) begin
            if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_ROUND_ROBIN_EN
                grant0 = !rrPtr_q;
                grant1 = rrPtr_q;
`else
                grant0 = 1'b1;
`endif
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
    end

    assign transfer   = grant0 | grant1;
    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign alu_op     = grant1 ? req1_op : req0_op;
    assign alu_a      = grant1 ? req1_a  : req0_a;
    assign alu_b      = grant1 ? req1_b  : req0_b;
    assign alu_cf_fwd = eflags_q[0];
    assign alu_af_fwd = eflags_q[4];
    assign grantOp    = op_e'(alu_op);

    always_comb begin
        flagMask = 32'h0;
        case (grantOp)
            OP_ADD, OP_OR, OP_DAA, OP_AND, OP_CMP: flagMask = ARITH_MASK;
            OP_CLD, OP_STD:                        flagMask = DF_MASK;
            default:                               flagMask = 32'h0;
        endcase
    end

    // A new transfer reloads the slot even while the old response drains, keeping full throughput
    always_comb begin
        rspValid_d  = rspValid_q;
        rspId_d     = rspId_q;
        rspResult_d = rspResult_q;
        rspFlags_d  = rspFlags_q;
        eflags_d    = eflags_q;
        if (transfer) begin
            rspValid_d  = 1'b1;
            rspId_d     = grant1;
            rspResult_d = alu_out;
            rspFlags_d  = alu_flags;
            eflags_d    = (eflags_q & ~flagMask) | (alu_flags & flagMask) | FIXED_ONE;
        end else if (rsp_ready) begin
            rspValid_d  = 1'b0;
        end
    end

`ifdef ALU_ARB_ROUND_ROBIN_EN
    assign rrPtr_d = transfer ? !grant1 : rrPtr_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            rspValid_q  <= 1'b0;
            rspId_q     <= 1'b0;
            rspResult_q <= 32'h0;
            rspFlags_q  <= 32'h0;
            eflags_q    <= FLAGS_RESET;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            rrPtr_q     <= 1'b0;
`endif
        end else begin
            rspValid_q  <= rspValid_d;
            rspId_q     <= rspId_d;
            rspResult_q <= rspResult_d;
            rspFlags_q  <= rspFlags_d;
            eflags_q    <= eflags_d;
`ifdef ALU_ARB_ROUND_ROBIN_EN
            rrPtr_q     <= rrPtr_d;
`endif
        end
    end

    assign rsp_valid  = rspValid_q;
    assign rsp_id     = rspId_q;
    assign rsp_result = rspResult_q;
    assign rsp_flags  = rspFlags_q;
    assign eflags     = eflags_q | FIXED_ONE;

endmodule
